mic_peak_level: RTL and testbench



---
 rtl/mic_peak_level_pkg.sv | 23 ++
 rtl/mic_peak_level_if.sv | 13 +
 rtl/mic_peak_level_sample_tick_gen.sv | 27 ++
 rtl/mic_peak_level.sv | 88 ++++++++
 tb/tb_mic_peak_level.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/mic_peak_level_pkg.sv
// Shared constants and helpers for the microphone level path.
package mic_pkg;
    localparam int ADC_W        = 12;
    localparam int LEVEL_W      = 5;
    localparam int MAX_LEVEL    = 9;
    localparam int DEF_BASELINE = 2048;
    localparam int DEF_STEP     = 200;

    // Amplitude threshold for level k; constant whenever k and step are constant.
    function automatic int level_threshold(input int k, input int step);
        return k * step;
    endfunction

    // Largest k in 0..MAX_LEVEL with amp >= k*step, built from constant compares.
    function automatic logic [LEVEL_W-1:0] quantize(input logic [ADC_W-1:0] amp, input int step);
        logic [LEVEL_W-1:0] lvl;
        lvl = '0;
        for (int k = 1; k <= MAX_LEVEL; k++) begin
            if (int'(amp) >= level_threshold(k, step)) lvl = LEVEL_W'(k);
        end
        return lvl;
    endfunction
endpackage

// File: rtl/mic_peak_level_if.sv
// Sample-in / level-out bundle between the mic front end and the display stage.
interface mic_peak_level_if;
    import mic_pkg::*;

    logic [ADC_W-1:0]   MIC_IN;
    logic [LEVEL_W-1:0] audio_level;
    logic               level_valid;
    logic [ADC_W-1:0]   peak_out;
    logic               sample_tick;

    modport master (output MIC_IN, input audio_level, level_valid, peak_out, sample_tick);
    modport slave  (input MIC_IN, output audio_level, level_valid, peak_out, sample_tick);
endinterface

// File: rtl/mic_peak_level_sample_tick_gen.sv
// Free-running divider producing a registered one-cycle tick every DIV cycles.
// wrap is the combinational precursor, true on the edge where tick asserts.
module sample_tick_gen #(
    parameter int DIV = 10
) (
    input  logic basys_clock,
    input  logic reset,
    output logic wrap,
    output logic tick
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign wrap = (cnt == CNT_W'(DIV - 1));

    // Count 0..DIV-1 and register a tick on each wrap.
    always_ff @(posedge basys_clock or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            cnt  <= wrap ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mic_peak_level.sv
// Mic peak detector: decimate MIC_IN, track the window peak, remove the idle
// baseline and quantize to a 0..9 level held until the next window.
module mic_peak_level import mic_pkg::*; #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int SAMPLE_HZ      = 20_000,
    parameter int WINDOW_SAMPLES = 4000,
    parameter int BASELINE       = DEF_BASELINE,
    parameter int STEP           = DEF_STEP
) (
    input  logic             basys_clock,
    input  logic             reset,
    mic_peak_level_if.slave  bus
);
    localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int WIN_W      = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
    localparam int STAGES     = 1;

    logic               wrap, tick;
    logic [ADC_W-1:0]   sample_q;
    logic [ADC_W-1:0]   running_peak;
    logic [WIN_W-1:0]   win_cnt;
    logic [ADC_W-1:0]   amp_q;
    logic [ADC_W-1:0]   peak_q;
    logic [LEVEL_W-1:0] level_q;
    logic [STAGES:0]    vld_pipe;

    logic [ADC_W-1:0]   peak_max;
    logic [ADC_W-1:0]   amp_next;
    logic               last_sample;

    sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
        .basys_clock (basys_clock),
        .reset       (reset),
        .wrap        (wrap),
        .tick        (tick)
    );

    assign peak_max    = (running_peak > sample_q) ? running_peak : sample_q;
    assign amp_next    = (peak_max > ADC_W'(BASELINE)) ? peak_max - ADC_W'(BASELINE) : '0;
    assign last_sample = (win_cnt == WIN_W'(WINDOW_SAMPLES - 1));

    // Capture MIC_IN on the same edge the tick asserts.
    always_ff @(posedge basys_clock or posedge reset) begin
        if (reset) sample_q <= '0;
        else if (wrap) sample_q <= bus.MIC_IN;
    end

    // Fold the captured sample into the window peak; close the window on the last one.
    always_ff @(posedge basys_clock or posedge reset) begin
        if (reset) begin
            running_peak <= '0;
            win_cnt      <= '0;
            peak_q       <= '0;
            amp_q        <= '0;
            vld_pipe[0]  <= 1'b0;
        end else begin
            vld_pipe[0] <= 1'b0;
            if (tick) begin
                if (last_sample) begin
                    peak_q       <= peak_max;
                    amp_q        <= amp_next;
                    running_peak <= '0;
                    win_cnt      <= '0;
                    vld_pipe[0]  <= 1'b1;
                end else begin
                    running_peak <= peak_max;
                    win_cnt      <= win_cnt + 1'b1;
                end
            end
        end
    end

    // Quantize the closed window's amplitude and pulse level_valid once.
    always_ff @(posedge basys_clock or posedge reset) begin
        if (reset) begin
            level_q     <= '0;
            vld_pipe[1] <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) level_q <= quantize(amp_q, STEP);
        end
    end

    assign bus.audio_level = level_q;
    assign bus.level_valid = vld_pipe[STAGES];
    assign bus.peak_out    = peak_q;
    assign bus.sample_tick = tick;
endmodule

// File: tb/tb_mic_peak_level.sv
// Bench for mic_peak_level: directed windows plus random windows, every
// cycle compared against a window-level model of the expected outputs.
module tb_mic_peak_level;
    localparam int CLK_HZ = 100, SAMPLE_HZ = 10, W = 4, BASE = 2048, STEP = 200;
    localparam int DIV = CLK_HZ / SAMPLE_HZ;

    logic basys_clock = 1'b0;
    logic reset = 1'b1;

    mic_peak_level_if bus ();

    mic_peak_level #(
        .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .WINDOW_SAMPLES(W),
        .BASELINE(BASE), .STEP(STEP)
    ) dut (
        .basys_clock (basys_clock),
        .reset       (reset),
        .bus         (bus.slave)
    );

    always #5 basys_clock = ~basys_clock;

    int n_asrt = 0, n_fail = 0;
    int cyc, exp_level, exp_peak, due_valid, due_peak, pend_level, pend_peak, prev_level;
    int q[$];
    int vq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: level from a window's samples by plain arithmetic.
    function automatic int ref_level(input int pk);
        int amp, lvl;
        amp = (pk > BASE) ? pk - BASE : 0;
        lvl = amp / STEP;
        return (lvl > 9) ? 9 : lvl;
    endfunction

    task automatic model_reset();
        cyc = 0; q.delete(); exp_level = 0; exp_peak = 0;
        due_valid = -1; due_peak = -1; prev_level = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_level"}, 32'(bus.audio_level), 0);
        chk({tag, "_valid"}, 32'(bus.level_valid), 0);
        chk({tag, "_peak"},  32'(bus.peak_out), 0);
        chk({tag, "_tick"},  32'(bus.sample_tick), 0);
    endtask

    // One clock with a full per-cycle comparison against the model.
    task automatic step();
        int v, mx;
        bit et;
        v = int'(bus.MIC_IN);
        @(posedge basys_clock); #1;
        cyc++;
        et = (cyc % DIV == 0);
        chk("sample_tick", 32'(bus.sample_tick), 32'(et));
        if (et) begin
            q.push_back(v);
            if (q.size() == W) begin
                mx = 0;
                foreach (q[i]) if (q[i] > mx) mx = q[i];
                pend_peak = mx; pend_level = ref_level(mx);
                due_peak = cyc + 1; due_valid = cyc + 2;
                q.delete();
            end
        end
        if (cyc == due_peak) exp_peak = pend_peak;
        if (cyc == due_valid) begin
            exp_level = pend_level;
            vq.push_back(cyc);
        end
        chk("level_valid", 32'(bus.level_valid), 32'(cyc == due_valid));
        chk("audio_level", 32'(bus.audio_level), 32'(exp_level));
        chk("peak_out",    32'(bus.peak_out), 32'(exp_peak));
        chk("level_change_without_valid",
            32'((int'(bus.audio_level) != prev_level) && !bus.level_valid), 0);
        prev_level = int'(bus.audio_level);
    endtask

    task automatic window(input int s0, input int s1, input int s2, input int s3);
        int s[4];
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            bus.MIC_IN = 12'(s[i]);
            repeat (DIV) step();
        end
    endtask

    initial begin
        int first_valid;
        model_reset();
        bus.MIC_IN = 12'd2048;

        // 1. reset hold, then idle window
        repeat (5) begin
            @(posedge basys_clock); #1;
            chk_zero("in_reset");
        end
        reset = 1'b0;
        model_reset();
        vq.delete();
        window(2048, 2048, 2048, 2048);
        repeat (2) step();
        first_valid = (vq.size() > 0) ? vq[0] : -1;
        chk("first_valid_cycle", 32'(first_valid), 42);
        chk("first_level", 32'(bus.audio_level), 0);
        chk("first_peak", 32'(bus.peak_out), 2048);

        // 2. threshold exactness
        window(2248, 2248, 2248, 2248);
        window(2247, 2247, 2247, 2247);
        // 3. saturation
        window(3848, 3848, 3848, 3848);
        window(3847, 3847, 3847, 3847);
        window(4095, 4095, 4095, 4095);
        // 4. mixed window, peak clear, underflow guard
        window(2048, 3000, 2048, 1000);
        window(2048, 2048, 2048, 2048);
        window(0, 0, 0, 0);
        // random windows
        for (int w = 0; w < 8; w++) begin
            if (w % 2 == 0)
                window($urandom_range(0, 4095), $urandom_range(0, 4095),
                       $urandom_range(0, 4095), $urandom_range(0, 4095));
            else
                window($urandom_range(1900, 4095), $urandom_range(1900, 2600),
                       $urandom_range(0, 2048), $urandom_range(2048, 4095));
        end
        repeat (2) step();

        // 5. reset in the middle of a window
        bus.MIC_IN = 12'd4095;
        repeat (2 * DIV + 3) step();
        #3 reset = 1'b1;
        #1 chk_zero("async_reset");
        model_reset();
        repeat (2) begin
            @(posedge basys_clock); #1;
            chk_zero("reset_hold");
        end
        reset = 1'b0;
        window(2048, 2048, 2048, 2048);
        repeat (2) step();
        chk("after_reset_level", 32'(bus.audio_level), 0);
        chk("after_reset_peak", 32'(bus.peak_out), 2048);

        // 6. pulse spacing over three consecutive windows
        vq.delete();
        window(2600, 2100, 2300, 2049);
        window(3100, 3100, 2000, 2000);
        window(2048, 2800, 2048, 2048);
        repeat (2) step();
        chk("valid_pulse_count", 32'(vq.size()), 3);
        for (int i = 1; i < vq.size(); i++)
            chk("valid_spacing", 32'(vq[i] - vq[i-1]), 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
